// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter
//
// Purpose:
//   Shares one unified instruction/data memory between two requesters:
//   the multicycle core's memory port and a program-loader/debug port.
//   It uses a req/ready handshake of variable latency towards the memory.
//   While the other side owns the memory, the core stays stalled.
//   A watchdog aborts any access that hangs.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   c_req/c_we/c_addr/c_wdata   core request and fields
//   c_rdata, c_ack      core read data (registered) and completion pulse
//   c_stall             combinational core stall = c_req & ~c_ack
//   l_req/l_we/l_addr/l_wdata   loader request and fields
//   l_lock              loader burst lock, keeps the core off the memory
//   l_rdata, l_ack      loader read data (registered) and completion pulse
//   m_req/m_we/m_addr/m_wdata   memory request and latched fields
//   m_rdata, m_ready    memory read data and completion
//   busy                a memory transaction is in flight
//   err                 sticky timeout flag, cleared only by rst
// ============================================================================
module mem_port_arbiter #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic          clk,
    input  logic          rst,
    // core port
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic [DW-1:0] c_rdata,
    output logic          c_ack,
    output logic          c_stall,
    // loader port
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    input  logic          l_lock,
    output logic [DW-1:0] l_rdata,
    output logic          l_ack,
    // memory port
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ready,
    // status
    output logic          busy,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CORE = 2'd1,
        LOAD = 2'd2
    } state_t;

    typedef enum logic {
        GNT_CORE   = 1'b0,
        GNT_LOADER = 1'b1
    } grant_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t          r_state;
    grant_t          r_last_grant;
    logic [7:0]      r_wait;
    logic [DW-1:0]   r_c_rdata;
    logic            r_c_ack;
    logic [DW-1:0]   r_l_rdata;
    logic            r_l_ack;
    logic            r_m_req;
    logic            r_m_we;
    logic [AW-1:0]   r_m_addr;
    logic [DW-1:0]   r_m_wdata;
    logic            r_busy;
    logic            r_err;

    // Next-state values
    state_t          w_state;
    grant_t          w_last_grant;
    logic [7:0]      w_wait;
    logic [DW-1:0]   w_c_rdata;
    logic            w_c_ack;
    logic [DW-1:0]   w_l_rdata;
    logic            w_l_ack;
    logic            w_m_req;
    logic            w_m_we;
    logic [AW-1:0]   w_m_addr;
    logic [DW-1:0]   w_m_wdata;
    logic            w_busy;
    logic            w_err;

    // Arbitration helpers
    logic            w_c_elig;
    logic            w_l_elig;
    logic            w_gnt_l;
    logic            w_gnt_c;
    logic            w_timeout;
    logic            w_finish;
    logic [DW-1:0]   w_ret_data;
    logic            w_ret_write;

    // A requester is never eligible in its own ack cycle. A held l_lock
    // also keeps the core off the memory, so a loader burst is not broken
    // up by core grants in the loader's ack cycles.
    assign w_c_elig = c_req & ~r_c_ack & ~l_lock;
    assign w_l_elig = l_req & ~r_l_ack;

    // Loader wins on lock, when alone, or on a tie when the core went last.
    assign w_gnt_l  = w_l_elig & (l_lock | ~w_c_elig | (r_last_grant == GNT_CORE));
    assign w_gnt_c  = w_c_elig & ~w_gnt_l;

    // m_ready has priority over the watchdog in the cycle the limit is hit.
    assign w_timeout = r_m_req & ~m_ready & (r_wait == WAIT_LIMIT);
    assign w_finish  = r_m_req & (m_ready | w_timeout);

    // A timeout returns all ones whatever the access type. A completed
    // write leaves rdata alone.
    assign w_ret_data  = w_timeout ? '1 : m_rdata;
    assign w_ret_write = r_m_we & ~w_timeout;

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state      = r_state;
        w_last_grant = r_last_grant;
        w_wait       = r_wait;
        w_c_rdata    = r_c_rdata;
        w_c_ack      = 1'b0;
        w_l_rdata    = r_l_rdata;
        w_l_ack      = 1'b0;
        w_m_req      = r_m_req;
        w_m_we       = r_m_we;
        w_m_addr     = r_m_addr;
        w_m_wdata    = r_m_wdata;
        w_busy       = r_busy;
        w_err        = r_err;

        case (r_state)
            IDLE: begin
                // m_ready is ignored here.
                if (w_gnt_l) begin
                    w_m_req      = 1'b1;
                    w_busy       = 1'b1;
                    w_m_we       = l_we;
                    w_m_addr     = l_addr;
                    w_m_wdata    = l_wdata;
                    w_last_grant = GNT_LOADER;
                    w_wait       = '0;
                    w_state      = LOAD;
                end else if (w_gnt_c) begin
                    w_m_req      = 1'b1;
                    w_busy       = 1'b1;
                    w_m_we       = c_we;
                    w_m_addr     = c_addr;
                    w_m_wdata    = c_wdata;
                    w_last_grant = GNT_CORE;
                    w_wait       = '0;
                    w_state      = CORE;
                end
            end

            CORE, LOAD: begin
                if (w_finish) begin
                    w_m_req = 1'b0;
                    w_busy  = 1'b0;
                    w_state = IDLE;
                    if (w_timeout) begin
                        w_err = 1'b1;
                    end
                    if (r_state == CORE) begin
                        w_c_ack = 1'b1;
                        if (!w_ret_write) begin
                            w_c_rdata = w_ret_data;
                        end
                    end else begin
                        w_l_ack = 1'b1;
                        if (!w_ret_write) begin
                            w_l_rdata = w_ret_data;
                        end
                    end
                end else if (r_m_req) begin
                    w_wait = r_wait + 8'd1;
                end
            end

            default: begin
                w_state = IDLE;
                w_m_req = 1'b0;
                w_busy  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_last_grant <= GNT_LOADER;
            r_wait       <= '0;
            r_c_rdata    <= '0;
            r_c_ack      <= 1'b0;
            r_l_rdata    <= '0;
            r_l_ack      <= 1'b0;
            r_m_req      <= 1'b0;
            r_m_we       <= 1'b0;
            r_m_addr     <= '0;
            r_m_wdata    <= '0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_last_grant <= w_last_grant;
            r_wait       <= w_wait;
            r_c_rdata    <= w_c_rdata;
            r_c_ack      <= w_c_ack;
            r_l_rdata    <= w_l_rdata;
            r_l_ack      <= w_l_ack;
            r_m_req      <= w_m_req;
            r_m_we       <= w_m_we;
            r_m_addr     <= w_m_addr;
            r_m_wdata    <= w_m_wdata;
            r_busy       <= w_busy;
            r_err        <= w_err;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign c_rdata = r_c_rdata;
    assign c_ack   = r_c_ack;
    assign c_stall = c_req & ~r_c_ack;
    assign l_rdata = r_l_rdata;
    assign l_ack   = r_l_ack;
    assign m_req   = r_m_req;
    assign m_we    = r_m_we;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;
    assign busy    = r_busy;
    assign err     = r_err;

endmodule
